// File: rtl/ram64_bist_pkg.sv
// rtl/ram64_bist_pkg.sv - shared constants, state encoding and March C- element table for ram64_bist
package ram64_bist_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int N_ELEM = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CMP,
        S_NEXT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic down;
        logic has_rd;
        logic has_wr;
        logic rd_bg;
        logic wr_bg;
    } elem_t;

    // Fields: {down, has_rd, has_wr, rd_bg, wr_bg}; entries 6 and 7 are never reached.
    localparam elem_t [7:0] MARCH = {
        5'b00000,   // spare
        5'b00000,   // spare
        5'b01000,   // E5 up(r0)
        5'b11110,   // E4 down(r1,w0)
        5'b11101,   // E3 down(r0,w1)
        5'b01110,   // E2 up(r1,w0)
        5'b01101,   // E1 up(r0,w1)
        5'b00100    // E0 up(w0)
    };

endpackage

// File: rtl/ram64_bist_chk.sv
// rtl/ram64_bist_chk.sv - expected-value pipeline aligned to RAM read latency, plus per-port comparators
module ram64_bist_chk
    import ram64_bist_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_issue,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [DATA_W-1:0] d_out_a,
    input  logic [DATA_W-1:0] d_out_b,
    output logic              cmp_valid,
    output logic              mismatch_a,
    output logic              mismatch_b
);

    logic [DATA_W-1:0] exp_cmp;

    generate
        if (RD_LATENCY == 0) begin : g_comb
            wire unused_clk_rst = clk ^ reset;
            assign cmp_valid = rd_issue;
            assign exp_cmp   = exp_data;
        end else begin : g_pipe
            logic [RD_LATENCY-1:0] vld_q;
            logic [DATA_W-1:0]     exp_q [RD_LATENCY];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < RD_LATENCY; i++) exp_q[i] <= '0;
                end else begin
                    vld_q[0] <= rd_issue;
                    exp_q[0] <= exp_data;
                    for (int i = 1; i < RD_LATENCY; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        exp_q[i] <= exp_q[i-1];
                    end
                end
            end

            assign cmp_valid = vld_q[RD_LATENCY-1];
            assign exp_cmp   = exp_q[RD_LATENCY-1];
        end
    endgenerate

    assign mismatch_a = cmp_valid && (d_out_a != exp_cmp);
    assign mismatch_b = cmp_valid && (d_out_b != exp_cmp);

endmodule

// File: rtl/ram64_bist.sv
// rtl/ram64_bist.sv - March C- BIST initiator for the 8x16 ram64 register file
module ram64_bist
    import ram64_bist_pkg::*;
#(
    parameter int                RD_LATENCY = 1,
    parameter logic [DATA_W-1:0] PATTERN    = 16'hA5A5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic              fail_port,
    output logic [DATA_W-1:0] fail_data,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_d_in,
    output logic [ADDR_W-1:0] ram_rd_addr_a,
    output logic [ADDR_W-1:0] ram_rd_addr_b,
    input  logic [DATA_W-1:0] ram_d_out_a,
    input  logic [DATA_W-1:0] ram_d_out_b
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LAST_ELEM = 3'(N_ELEM - 1);

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pass_q, pass_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]        fail_elem_q, fail_elem_d;
    logic              fail_port_q, fail_port_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    elem_t             cur;
    logic [DATA_W-1:0] exp_rd, wr_data;
    logic              cmp_valid, mismatch_a, mismatch_b;
    logic              step, last;

    assign cur     = MARCH[elem_q];
    assign exp_rd  = cur.rd_bg ? ~PATTERN : PATTERN;
    assign wr_data = cur.wr_bg ? ~PATTERN : PATTERN;

    ram64_bist_chk #(.RD_LATENCY(RD_LATENCY)) u_chk (
        .clk        (clk),
        .reset      (reset),
        .rd_issue   (state_q == S_RD),
        .exp_data   (exp_rd),
        .d_out_a    (ram_d_out_a),
        .d_out_b    (ram_d_out_b),
        .cmp_valid  (cmp_valid),
        .mismatch_a (mismatch_a),
        .mismatch_b (mismatch_b)
    );

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        fail_port_d = fail_port_q;
        fail_data_d = fail_data_q;
        step        = 1'b0;
        last        = cur.down ? (addr_q == '0) : (addr_q == LAST_ADDR);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_WR;
                    elem_d      = '0;
                    addr_d      = '0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_elem_d = '0;
                    fail_port_d = 1'b0;
                    fail_data_d = '0;
                end
            end
            S_WR: step = 1'b1;
            S_RD, S_CMP: begin
                if (!cmp_valid) begin
                    state_d = S_CMP;
                end else if (mismatch_a || mismatch_b) begin
                    // Port A wins when both ports disagree.
                    state_d     = S_DONE;
                    pass_d      = 1'b0;
                    fail_addr_d = addr_q;
                    fail_elem_d = elem_q;
                    fail_port_d = !mismatch_a;
                    fail_data_d = mismatch_a ? ram_d_out_a : ram_d_out_b;
                end else if (cur.has_wr) begin
                    state_d = S_WR;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address/element advance happens in the last op cycle so no dead cycles are spent between ops.
        if (step) begin
            if (!last) begin
                addr_d  = cur.down ? addr_q - 1'b1 : addr_q + 1'b1;
                state_d = cur.has_rd ? S_RD : S_WR;
            end else if (elem_q == LAST_ELEM) begin
                state_d = S_DONE;
                pass_d  = 1'b1;
            end else begin
                elem_d  = elem_q + 3'd1;
                addr_d  = MARCH[elem_q + 3'd1].down ? LAST_ADDR : '0;
                state_d = MARCH[elem_q + 3'd1].has_rd ? S_RD : S_WR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            elem_q      <= '0;
            addr_q      <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_port_q <= 1'b0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            fail_port_q <= fail_port_d;
            fail_data_q <= fail_data_d;
        end
    end

    // Outputs decode straight from the state register so an async reset zeroes them at once.
    assign busy          = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_CMP);
    assign done          = (state_q == S_DONE);
    assign pass          = pass_q;
    assign fail_addr     = fail_addr_q;
    assign fail_elem     = fail_elem_q;
    assign fail_port     = fail_port_q;
    assign fail_data     = fail_data_q;
    assign ram_wr        = (state_q == S_WR);
    assign ram_wr_addr   = ram_wr ? addr_q : '0;
    assign ram_d_in      = ram_wr ? wr_data : '0;
    assign ram_rd_addr_a = ((state_q == S_RD) || (state_q == S_CMP)) ? addr_q : '0;
    assign ram_rd_addr_b = ram_rd_addr_a;

endmodule

// File: tb/tb_ram64_bist.sv
// tb/tb_ram64_bist.sv - scoreboard bench for ram64_bist with RAM models and injectable read-port stuck-at faults
module tb_ram64_bist;

    localparam logic [15:0] PAT = 16'hA5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start1, start0;

    logic        busy1, done1, pass1, fport1, wr1;
    logic [2:0]  faddr1, felem1, wa1, ra1, rb1;
    logic [15:0] fdata1, din1, doa1, dob1;
    logic        busy0, done0, pass0, fport0, wr0;
    logic [2:0]  faddr0, felem0, wa0, ra0, rb0;
    logic [15:0] fdata0, din0, doa0, dob0;

    ram64_bist #(.RD_LATENCY(1), .PATTERN(PAT)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_addr(faddr1), .fail_elem(felem1), .fail_port(fport1), .fail_data(fdata1),
        .ram_wr(wr1), .ram_wr_addr(wa1), .ram_d_in(din1),
        .ram_rd_addr_a(ra1), .ram_rd_addr_b(rb1), .ram_d_out_a(doa1), .ram_d_out_b(dob1)
    );

    ram64_bist #(.RD_LATENCY(0), .PATTERN(PAT)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_addr(faddr0), .fail_elem(felem0), .fail_port(fport0), .fail_data(fdata0),
        .ram_wr(wr0), .ram_wr_addr(wa0), .ram_d_in(din0),
        .ram_rd_addr_a(ra0), .ram_rd_addr_b(rb0), .ram_d_out_a(doa0), .ram_d_out_b(dob0)
    );

    // Fault: one read port returns bit f_bit stuck at f_val for address f_addr.
    bit         f_en = 1'b0;
    bit         f_port = 1'b0;
    logic [2:0] f_addr = '0;
    logic [3:0] f_bit = '0;
    bit         f_val = 1'b0;

    logic [15:0] mem1 [8];
    logic [15:0] mem0 [8];
    logic [15:0] qa1, qb1;
    logic [2:0]  qra1, qrb1;

    always @(posedge clk) begin
        if (wr1) mem1[wa1] <= din1;
        if (wr0) mem0[wa0] <= din0;
        qa1  <= mem1[ra1];
        qb1  <= mem1[rb1];
        qra1 <= ra1;
        qrb1 <= rb1;
    end

    always_comb begin
        doa1 = qa1;
        dob1 = qb1;
        doa0 = mem0[ra0];
        dob0 = mem0[rb0];
        if (f_en && !f_port && qra1 == f_addr) doa1[f_bit] = f_val;
        if (f_en &&  f_port && qrb1 == f_addr) dob1[f_bit] = f_val;
        if (f_en && !f_port && ra0  == f_addr) doa0[f_bit] = f_val;
        if (f_en &&  f_port && rb0  == f_addr) dob0[f_bit] = f_val;
    end

    typedef struct {
        int          cycles;
        bit          pass;
        logic [2:0]  addr;
        logic [2:0]  elem;
        bit          port;
        logic [15:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_port(input logic [15:0] v, input bit port, input int a);
        logic [15:0] r;
        r = v;
        if (f_en && port == f_port && a == int'(f_addr)) r[f_bit] = f_val;
        return r;
    endfunction

    // March C- walked element by element over an array; a read costs 1+lat cycles, a write 1.
    function automatic exp_t model(input int lat);
        exp_t        r;
        logic [15:0] m [8];
        logic [15:0] va, vb, ev;
        int down [6]  = '{0, 0, 0, 1, 1, 0};
        int has_r [6] = '{0, 1, 1, 1, 1, 1};
        int has_w [6] = '{1, 1, 1, 1, 1, 0};
        int rbg [6]   = '{0, 0, 1, 0, 1, 0};
        int wbg [6]   = '{0, 1, 0, 1, 0, 0};
        r.cycles = 0; r.pass = 1'b1; r.addr = '0; r.elem = '0; r.port = 1'b0; r.data = '0;
        for (int i = 0; i < 8; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 8; k++) begin
                int a;
                a = (down[e] != 0) ? 7 - k : k;
                if (has_r[e] != 0) begin
                    r.cycles += 1 + lat;
                    ev = (rbg[e] != 0) ? ~PAT : PAT;
                    va = rd_port(m[a], 1'b0, a);
                    vb = rd_port(m[a], 1'b1, a);
                    if (va !== ev || vb !== ev) begin
                        r.pass = 1'b0;
                        r.addr = 3'(a);
                        r.elem = 3'(e);
                        r.port = (va === ev);
                        r.data = (va !== ev) ? va : vb;
                        return r;
                    end
                end
                if (has_w[e] != 0) begin
                    m[a] = (wbg[e] != 0) ? ~PAT : PAT;
                    r.cycles += 1;
                end
            end
        end
        return r;
    endfunction

    task automatic score(input bit which);
        exp_t e;
        string t;
        t = which ? "dut1" : "dut0";
        if ((which ? q1.size() : q0.size()) == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s unexpected_done: got done, expected none", t);
            return;
        end
        if (which) e = q1.pop_front(); else e = q0.pop_front();
        check({t, " done_cycle"}, cyc, e.cycles);
        check({t, " pass"},      which ? pass1  : pass0,  e.pass);
        check({t, " fail_addr"}, which ? faddr1 : faddr0, e.addr);
        check({t, " fail_elem"}, which ? felem1 : felem0, e.elem);
        check({t, " fail_port"}, which ? fport1 : fport0, e.port);
        check({t, " fail_data"}, which ? fdata1 : fdata0, e.data);
    endtask

    logic done1_prev = 1'b0;
    logic done0_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (done1 && !done1_prev) score(1'b1);
        if (done0 && !done0_prev) score(1'b0);
        done1_prev = done1;
        done0_prev = done0;
        check("rd_addr_b_eq_a dut1", rb1, ra1);
        check("rd_addr_b_eq_a dut0", rb0, ra0);
    end

    // Returns at the negedge after start was sampled; n is the sampling edge.
    task automatic launch(input bit which, input exp_t e, output int n);
        @(negedge clk);
        n = cyc + 1;
        e.cycles = n + e.cycles;
        if (which) begin q1.push_back(e); start1 = 1'b1; end
        else       begin q0.push_back(e); start0 = 1'b1; end
        @(negedge clk);
        start1 = 1'b0;
        start0 = 1'b0;
        check("launch done_cleared", which ? done1 : done0, 0);
        check("launch pass_cleared", which ? pass1 : pass0, 0);
        check("launch busy",         which ? busy1 : busy0, 1);
        check("launch e0_write",     which ? {wr1, wa1, din1} : {wr0, wa0, din0}, {1'b1, 3'd0, PAT});
    endtask

    task automatic wait_done(input bit which, output int seen);
        seen = -1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if ((which ? done1 : done0) === 1'b1) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) begin
            n_chk++; n_fail++;
            $display("FAIL wait_done: got no done within 400 cycles, expected done");
            if (which) q1.delete(); else q0.delete();
        end
    endtask

    task automatic check_mem(input bit which);
        for (int i = 0; i < 8; i++)
            check($sformatf("mem_after_pass dut%0d addr%0d", which, i), which ? mem1[i] : mem0[i], PAT);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, " dut1_outputs"},
              {busy1, done1, pass1, fport1, wr1, faddr1, felem1, wa1, ra1, rb1, fdata1, din1}, 64'd0);
        check({name, " dut0_outputs"},
              {busy0, done0, pass0, fport0, wr0, faddr0, felem0, wa0, ra0, rb0, fdata0, din0}, 64'd0);
    endtask

    initial begin
        int   n, seen;
        bit   which;
        exp_t e;

        reset  = 1'b0;
        start1 = 1'b0;
        start0 = 1'b0;

        // Reset held with start toggling: nothing may move.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start1 = 1'($urandom_range(0, 1));
            start0 = 1'($urandom_range(0, 1));
            #2;
            check_idle_outputs("reset_hold");
        end
        @(negedge clk);
        start1 = 1'b0;
        start0 = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // Good RAM, latency 1.
        launch(1'b1, model(1), n);
        wait_done(1'b1, seen);
        check("t2 latency", seen - n, 120);
        check("t2 pass", pass1, 1);
        check_mem(1'b1);

        // Port B, addr 5, bit 0 stuck at 0.
        f_en = 1'b1; f_port = 1'b1; f_addr = 3'd5; f_bit = 4'd0; f_val = 1'b0;
        launch(1'b1, model(1), n);
        wait_done(1'b1, seen);
        check("t3 pass", pass1, 0);
        check("t3 fail_addr", faddr1, 5);
        check("t3 fail_elem", felem1, 1);
        check("t3 fail_port", fport1, 1);
        check("t3 fail_data", fdata1, 16'hA5A4);
        f_en = 1'b0;

        // Asynchronous reset mid-test, then a clean rerun.
        launch(1'b1, model(1), n);
        repeat (40) @(negedge clk);
        check("t4 busy_before_reset", busy1, 1);
        #2 reset = 1'b0;
        #1;
        check("t4 busy_async_drop", busy1, 0);
        check("t4 wr_async_drop", wr1, 0);
        check_idle_outputs("t4 async_reset");
        void'(q1.pop_back());
        @(negedge clk);
        reset = 1'b1;
        launch(1'b1, model(1), n);
        wait_done(1'b1, seen);
        check("t4 rerun_latency", seen - n, 120);
        check("t4 rerun_pass", pass1, 1);

        // Extra start while busy.
        launch(1'b1, model(1), n);
        repeat (49) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1'b1, seen);
        check("t5 latency", seen - n, 120);

        // Combinational-read RAM, latency 0.
        launch(1'b0, model(0), n);
        wait_done(1'b0, seen);
        check("t6 latency", seen - n, 80);
        check("t6 pass", pass0, 1);
        check_mem(1'b0);

        // Randomized faults on either instance.
        for (int i = 0; i < 10; i++) begin
            which  = 1'($urandom_range(0, 1));
            f_en   = ($urandom_range(0, 2) != 0);
            f_port = 1'($urandom_range(0, 1));
            f_addr = 3'($urandom_range(0, 7));
            f_bit  = 4'($urandom_range(0, 15));
            f_val  = 1'($urandom_range(0, 1));
            e = model(which ? 1 : 0);
            launch(which, e, n);
            wait_done(which, seen);
            if (seen >= 0 && e.pass) check_mem(which);
        end
        f_en = 1'b0;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
